alarm_ring_ctrl: RTL and testbench

- Alarm sequencing controller for the digital alarm clock.
- Consumes single-cycle enable pulses from the system prescaler: a 4 Hz tick and a minute-rollover tick.
- Compares the running time against the alarm setting and sequences ringing, snooze and timeout.
- Drives the buzzer with a gated beep cadence. Everything runs on the system clock; no derived clocks.

---
 rtl/alarm_pkg.sv | 14 +
 rtl/alarm_beep_gen.sv | 45 ++++
 rtl/alarm_ring_ctrl.sv | 145 ++++++++++++++
 tb/tb_alarm_ring_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared types and widths for the alarm clock ring controller.
package alarm_pkg;

  localparam int DEF_TICK_HZ = 4;
  localparam int HOUR_W      = 5;
  localparam int MIN_W       = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_e;

endpackage

// File: rtl/alarm_beep_gen.sv
// Beep cadence generator: phase counter advanced by tick, buzzer on for the
// first BEEP_ON phases of each BEEP_PERIOD. Output is registered.
module alarm_beep_gen #(
  parameter int BEEP_PERIOD = 2,
  parameter int BEEP_ON     = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic tick,
  output logic beep
);

  localparam int PH_W = (BEEP_PERIOD > 1) ? $clog2(BEEP_PERIOD) : 1;

  logic [PH_W-1:0] phase_q, phase_d;
  logic            beep_q, beep_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    phase_d = phase_q;
    if (clr || !en) begin
      phase_d = '0;
    end else if (tick) begin
      phase_d = (phase_q == PH_W'(BEEP_PERIOD - 1)) ? '0 : phase_q + PH_W'(1);
    end
    // Computed from the next phase so the buzzer lines up with the state register.
    beep_d = en && (phase_d < PH_W'(BEEP_ON));
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      beep_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      beep_q  <= beep_d;
    end
  end

  assign beep = beep_q;

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Alarm ring/snooze/timeout sequencer with gated buzzer cadence.
// Define ALARM_ESCALATE_EN to hold the buzzer on for the second half of RING.
module alarm_ring_ctrl
  import alarm_pkg::*;
#(
  parameter int TICK_HZ     = DEF_TICK_HZ,
  parameter int RING_SEC    = 60,
  parameter int SNOOZE_MIN  = 5,
  parameter int MAX_SNOOZE  = 3,
  parameter int BEEP_PERIOD = 2,
  parameter int BEEP_ON     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_4hz,
  input  logic              min_tick,
  input  logic [HOUR_W-1:0] cur_hour,
  input  logic [MIN_W-1:0]  cur_min,
  input  logic [HOUR_W-1:0] alarm_hour,
  input  logic [MIN_W-1:0]  alarm_min,
  input  logic              alarm_en,
  input  logic              key_stop,
  input  logic              key_snooze,
  output logic              buzzer_out,
  output logic              ringing,
  output logic              snoozed,
  output logic [1:0]        snooze_used
);

  localparam int RING_TICKS = RING_SEC * TICK_HZ;
  localparam int CNT_W      = $clog2(RING_TICKS);
  localparam int SL_W       = $clog2(SNOOZE_MIN + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  ring_cnt_q, ring_cnt_d;
  logic [SL_W-1:0]   snooze_left_q, snooze_left_d;
  logic [1:0]        snooze_used_q, snooze_used_d;
  logic              ringing_q, ringing_d;
  logic              snoozed_q, snoozed_d;
  logic              time_match, timeout, ring_entry, beep;

  always_comb begin
    state_d       = state_q;
    ring_cnt_d    = ring_cnt_q;
    snooze_left_d = snooze_left_q;
    snooze_used_d = snooze_used_q;
    time_match    = min_tick && (cur_hour == alarm_hour) && (cur_min == alarm_min);
    timeout       = tick_4hz && (ring_cnt_q == CNT_W'(RING_TICKS - 1));

    if (!alarm_en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          // A match coinciding with stop is swallowed; the next match is a day later.
          if (time_match && !key_stop) begin
            state_d       = RING;
            ring_cnt_d    = '0;
            snooze_used_d = '0;
          end
        end
        RING: begin
          if (key_stop || timeout) begin
            state_d = IDLE;
          end else if (key_snooze && (snooze_used_q < 2'(MAX_SNOOZE))) begin
            state_d       = SNOOZE;
            snooze_used_d = snooze_used_q + 2'd1;
            snooze_left_d = SL_W'(SNOOZE_MIN);
          end else if (tick_4hz) begin
            ring_cnt_d = ring_cnt_q + CNT_W'(1);
          end
        end
        SNOOZE: begin
          if (key_stop) begin
            state_d = IDLE;
          end else if (min_tick) begin
            snooze_left_d = snooze_left_q - SL_W'(1);
            if (snooze_left_q == SL_W'(1)) begin
              state_d    = RING;
              ring_cnt_d = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    ring_entry = (state_d == RING) && (state_q != RING);
    ringing_d  = (state_d == RING);
    snoozed_d  = (state_d == SNOOZE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ring_cnt_q    <= '0;
      snooze_left_q <= '0;
      snooze_used_q <= '0;
      ringing_q     <= 1'b0;
      snoozed_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ring_cnt_q    <= ring_cnt_d;
      snooze_left_q <= snooze_left_d;
      snooze_used_q <= snooze_used_d;
      ringing_q     <= ringing_d;
      snoozed_q     <= snoozed_d;
    end
  end

  alarm_beep_gen #(
    .BEEP_PERIOD(BEEP_PERIOD),
    .BEEP_ON    (BEEP_ON)
  ) u_beep (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (ring_entry),
    .en   (ringing_d),
    .tick (tick_4hz),
    .beep (beep)
  );

`ifdef ALARM_ESCALATE_EN
  logic esc_q, esc_d;

  // Continuous tone once half the ring window has elapsed; a snooze re-entry clears ring_cnt.
  always_comb begin
    esc_d = ringing_d && (ring_cnt_d >= CNT_W'(RING_TICKS / 2));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) esc_q <= 1'b0;
    else        esc_q <= esc_d;
  end

  assign buzzer_out = beep | esc_q;
`else
  assign buzzer_out = beep;
`endif

  assign ringing     = ringing_q;
  assign snoozed     = snoozed_q;
  assign snooze_used = snooze_used_q;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Directed self-checking bench for alarm_ring_ctrl (default parameters, 07:30 alarm).
module tb_alarm_ring_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_4hz, min_tick, alarm_en, key_stop, key_snooze;
  logic [4:0] cur_hour, alarm_hour;
  logic [5:0] cur_min, alarm_min;
  logic       buzzer_out, ringing, snoozed;
  logic [1:0] snooze_used;

  int errors = 0;
  int checks = 0;

  alarm_ring_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_4hz   (tick_4hz),
    .min_tick   (min_tick),
    .cur_hour   (cur_hour),
    .cur_min    (cur_min),
    .alarm_hour (alarm_hour),
    .alarm_min  (alarm_min),
    .alarm_en   (alarm_en),
    .key_stop   (key_stop),
    .key_snooze (key_snooze),
    .buzzer_out (buzzer_out),
    .ringing    (ringing),
    .snoozed    (snoozed),
    .snooze_used(snooze_used)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive a set of one-cycle pulses, then return 1 time unit after the sampling edge.
  task automatic pulse(input logic t, input logic m, input logic s, input logic p);
    tick_4hz = t; min_tick = m; key_snooze = s; key_stop = p;
    @(posedge clk); #1;
    tick_4hz = 1'b0; min_tick = 1'b0; key_snooze = 1'b0; key_stop = 1'b0;
  endtask

  function automatic logic exp_beep(input int k);
`ifdef ALARM_ESCALATE_EN
    if (k >= 120) return 1'b1;
`endif
    return (k % 2) == 0;
  endfunction

  initial begin
    rst_n = 1'b0;
    tick_4hz = 1'b0; min_tick = 1'b0; key_stop = 1'b0; key_snooze = 1'b0;
    alarm_en = 1'b1;
    alarm_hour = 5'd7; alarm_min = 6'd30;
    cur_hour = 5'd7;   cur_min = 6'd29;
    #12;
    check("reset_ringing", ringing, 0);
    check("reset_snoozed", snoozed, 0);
    check("reset_buzzer", buzzer_out, 0);
    check("reset_used", snooze_used, 0);
    rst_n = 1'b1;

    // Non-matching minute and disarmed match must not ring.
    pulse(0, 1, 0, 0);
    check("nomatch_ringing", ringing, 0);
    cur_min = 6'd30; alarm_en = 1'b0;
    pulse(0, 1, 0, 0);
    check("disarmed_ringing", ringing, 0);
    alarm_en = 1'b1;

    // Match starts RING; full 240-tick ring with a mid-ring match and a final snooze collision.
    pulse(0, 1, 0, 0);
    check("match_ringing", ringing, 1);
    check("match_buzzer", buzzer_out, 1);
    check("match_used", snooze_used, 0);
    for (int k = 1; k <= 240; k++) begin
      if (k == 100) begin
        pulse(0, 1, 0, 0);
        check("rematch_ignored", ringing, 1);
      end
      if (k == 240) begin
        pulse(1, 0, 1, 0);
        check("timeout_ringing", ringing, 0);
        check("timeout_snoozed", snoozed, 0);
        check("timeout_buzzer", buzzer_out, 0);
      end else begin
        pulse(1, 0, 0, 0);
        check($sformatf("ring_k%0d", k), ringing, 1);
        check($sformatf("beep_k%0d", k), buzzer_out, exp_beep(k));
      end
    end
    pulse(0, 0, 0, 0);
    check("idle_buzzer", buzzer_out, 0);

    // Three snoozes, fourth ignored, then ring_cnt must restart from the last re-entry.
    pulse(0, 1, 0, 0);
    check("ring2_ringing", ringing, 1);
    cur_min = 6'd31;
    for (int k = 0; k < 10; k++) pulse(1, 0, 0, 0);
    for (int n = 1; n <= 3; n++) begin
      pulse(0, 0, 1, 0);
      check("snz_snoozed", snoozed, 1);
      check("snz_ringing", ringing, 0);
      check("snz_used", snooze_used, n);
      check("snz_buzzer", buzzer_out, 0);
      for (int m = 0; m < 4; m++) pulse(0, 1, 0, 0);
      check("snz_still", snoozed, 1);
      pulse(0, 1, 0, 0);
      check("resume_ringing", ringing, 1);
      check("resume_snoozed", snoozed, 0);
      check("resume_buzzer", buzzer_out, 1);
      pulse(1, 0, 0, 0);
      check("resume_beep_off", buzzer_out, 0);
    end
    pulse(0, 0, 1, 0);
    check("snz4_ringing", ringing, 1);
    check("snz4_snoozed", snoozed, 0);
    check("snz4_used", snooze_used, 3);
    for (int k = 0; k < 238; k++) pulse(1, 0, 0, 0);
    check("recnt_before", ringing, 1);
    pulse(1, 0, 0, 0);
    check("recnt_timeout", ringing, 0);
    check("recnt_used", snooze_used, 3);

    // Stop and snooze together: stop wins, counter unchanged.
    cur_min = 6'd30;
    pulse(0, 1, 0, 0);
    check("ring3_ringing", ringing, 1);
    check("ring3_used_cleared", snooze_used, 0);
    cur_min = 6'd31;
    pulse(0, 0, 1, 1);
    check("stopsnz_ringing", ringing, 0);
    check("stopsnz_snoozed", snoozed, 0);
    check("stopsnz_used", snooze_used, 0);
    pulse(0, 1, 0, 0);
    check("after_stop_min", ringing, 0);
    cur_min = 6'd30;
    pulse(0, 1, 0, 1);
    check("match_with_stop", ringing, 0);

    // alarm_en dropped during SNOOZE.
    pulse(0, 1, 0, 0);
    check("ring4_ringing", ringing, 1);
    cur_min = 6'd31;
    pulse(0, 0, 1, 0);
    check("ring4_snoozed", snoozed, 1);
    alarm_en = 1'b0;
    pulse(0, 0, 0, 0);
    check("disarm_snoozed", snoozed, 0);
    check("disarm_ringing", ringing, 0);
    alarm_en = 1'b1;
    pulse(0, 1, 0, 0);
    check("rearm_idle", ringing, 0);

    // Asynchronous reset while ringing after one snooze.
    cur_min = 6'd30;
    pulse(0, 1, 0, 0);
    cur_min = 6'd31;
    pulse(0, 0, 1, 0);
    for (int m = 0; m < 5; m++) pulse(0, 1, 0, 0);
    check("ring5_used", snooze_used, 1);
    pulse(1, 0, 0, 0);
    pulse(1, 0, 0, 0);
    check("ring5_buzzer", buzzer_out, 1);
    rst_n = 1'b0;
    #1;
    check("arst_ringing", ringing, 0);
    check("arst_buzzer", buzzer_out, 0);
    check("arst_used", snooze_used, 0);
    check("arst_snoozed", snoozed, 0);
    #2;
    rst_n = 1'b1;
    pulse(1, 0, 0, 0);
    check("post_rst_ringing", ringing, 0);
    check("post_rst_buzzer", buzzer_out, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
